zif_prog_sequencer: RTL and testbench
=====================================

Name: zif_prog_sequencer

Overview:
Sequences one byte-wide programming or read cycle on the ZIF socket, clocked by the 12 MHz oscillator.
The microcontroller bus front-end loads timing and data registers, then issues a command. The block then drives data, output-enable and the programming pulse with tick-accurate setup, pulse and hold phases.
It sits between the bus register decode and the ZIF pin bufif drivers. Its busy/status flags and sampled read data are returned through the bus read mux.

Parameters:
CNT_W, 16, width of phase counters and of the pulse-width register
SETUP_RST, 12, reset value of setup ticks (1 us at 12 MHz)
PULSE_RST, 1200, reset value of pulse-width ticks (100 us)
HOLD_RST, 12, reset value of hold ticks

Ports:
osc  input  1  12 MHz clock, buffered oscillator
rst_n  input  1  asynchronous active-low reset
reg_we  input  1  one-cycle write strobe, already synchronised to osc
reg_addr  input  8  register address
reg_wdata  input  8  write data
reg_rdata  output  8  combinational read mux of the addressed register
busy  output  1  high while a sequence runs
zif_dout  output  8  data driven to the ZIF data pins
zif_doe  output  1  enable for the zif_dout drivers
zif_din  input  8  raw ZIF data pins
prog_n  output  1  programming pulse, active low
oe_n  output  1  device output enable, active low

Behaviour:
- Registers, all written via reg_we at reg_addr:
  - 0x10 DATA
  - 0x11 PW_LO and 0x12 PW_HI (pulse width)
  - 0x13 SETUP (8 bit)
  - 0x14 HOLD (8 bit)
  - 0x15 CMD: bit0 program, bit1 read, bit7 abort
  - 0x16 STATUS: bit0 busy, bit1 err, bit2 done; any write clears err and done
  - 0x17 RDATA: read-only sampled data
- reg_rdata returns 0x00 for unmapped addresses, and for 0x15 and 0x16 bits not defined above.
- Reset values (async, rst_n low):
  - state IDLE, busy 0, zif_doe 0, zif_dout 0x00, prog_n 1, oe_n 1
  - DATA 0x00, RDATA 0x00, err 0, done 0
  - timing registers take their *_RST values
- All outputs are registered, except reg_rdata.
- States: IDLE, SETUP, PULSE, HOLD.
- Start:
  - In IDLE, a CMD write with bit0=1 or bit1=1 enters SETUP on the next edge; busy rises on that same edge.
  - If bit0 and bit1 are both set, program wins.
  - A start clears done.
- Phase length: each phase lasts max(N,1) cycles, where N is the register value. The counter loads N-1 (or 0 when N=0) on phase entry and advances to the next phase at 0.
- Program sequence:
  - SETUP: zif_doe=1, zif_dout=DATA, prog_n=1.
  - PULSE: prog_n=0, for PW cycles.
  - HOLD: prog_n=1, data still driven.
  - Exit to IDLE: zif_doe=0, busy=0, done=1.
- Read sequence:
  - SETUP: zif_doe=0, oe_n=0.
  - On the last SETUP cycle, RDATA <= zif_din.
  - PULSE is skipped; go straight to HOLD with oe_n=0.
  - Exit to IDLE: oe_n=1, busy=0, done=1.
- Writes while busy:
  - Writes to DATA/PW/SETUP/HOLD are ignored.
  - A CMD write with bit0 or bit1 and without bit7 is ignored and sets err.
- Abort (CMD bit7, any state):
  - Next edge: IDLE, prog_n=1, oe_n=1, zif_doe=0, busy=0.
  - done is not set, and RDATA is unchanged unless sampling already completed.
  - Abort has priority over start in the same write.
  - Abort in IDLE is a no-op.
- Status write coinciding with completion: completion's done=1 wins.
- Counter never wraps: it holds at 0 outside active phases.
- Reset mid-sequence: outputs return to reset values immediately (async), with no glitch on prog_n beyond the deassertion itself.

Decomposition:
- Package zif_prog_pkg holds:
  - the state enum
  - register address constants 0x10-0x17
  - CMD/STATUS bit indices
- Sub-module zif_phase_timer:
  - CNT_W down-counter with load/zero-detect
  - loads max(N,1)-1 and flags last cycle

Test Plan:
- Reset defaults: after reset, reg_rdata at 0x16 = 0x00, at 0x13 = 0x0C; prog_n=1, oe_n=1, zif_doe=0.
- Program: DATA=0xA5, SETUP=2, PW=3, HOLD=1, CMD=0x01 -> busy 6 cycles; zif_doe=1/zif_dout=0xA5 for all 6; prog_n low exactly cycles 3-5; then STATUS=0x04.
- Read: zif_din=0x3C, SETUP=4, HOLD=2, CMD=0x02 -> oe_n low 6 cycles, zif_doe never 1, RDATA=0x3C, done=1.
- Zero timing: SETUP=0, PW_LO=PW_HI=0, HOLD=0, program -> each phase 1 cycle, busy 3 cycles.
- Busy collision: during PULSE write SETUP=0x50 and CMD=0x02 -> SETUP unchanged, err=1, sequence completes normally; STATUS write 0x00 clears err.
- Abort/reset: CMD=0x81 mid-PULSE -> next edge prog_n=1, busy=0, done=0; separately rst_n low mid-PULSE -> prog_n=1 without waiting for a clock edge.

Source files
------------

// File: rtl/zif_prog_pkg.sv
// Shared types and register map for the ZIF programming sequencer.
package zif_prog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  typedef enum logic {
    MODE_PROG = 1'b0,
    MODE_READ = 1'b1
  } mode_t;

  localparam logic [7:0] ADDR_DATA   = 8'h10;
  localparam logic [7:0] ADDR_PW_LO  = 8'h11;
  localparam logic [7:0] ADDR_PW_HI  = 8'h12;
  localparam logic [7:0] ADDR_SETUP  = 8'h13;
  localparam logic [7:0] ADDR_HOLD   = 8'h14;
  localparam logic [7:0] ADDR_CMD    = 8'h15;
  localparam logic [7:0] ADDR_STATUS = 8'h16;
  localparam logic [7:0] ADDR_RDATA  = 8'h17;

  localparam int CMD_PROG_BIT  = 0;
  localparam int CMD_READ_BIT  = 1;
  localparam int CMD_ABORT_BIT = 7;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_ERR_BIT  = 1;
  localparam int STAT_DONE_BIT = 2;

endpackage

// File: rtl/zif_phase_timer.sv
// Phase down-counter: loads max(N,1)-1 on phase entry and flags the last cycle at zero.
module zif_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clr,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt;

  // Count down within a phase; a zero length still gives one cycle, and zero is held, never wrapped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (load_val == '0) ? '0 : load_val - ONE;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/zif_prog_sequencer.sv
// Sequences one program or read cycle on the ZIF socket with setup/pulse/hold timing.
module zif_prog_sequencer
  import zif_prog_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int SETUP_RST = 12,
  parameter int PULSE_RST = 1200,
  parameter int HOLD_RST  = 12
) (
  input  logic       osc,
  input  logic       rst_n,
  input  logic       reg_we,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic [7:0] reg_rdata,
  output logic       busy,
  output logic [7:0] zif_dout,
  output logic       zif_doe,
  input  logic [7:0] zif_din,
  output logic       prog_n,
  output logic       oe_n
);

  state_t state, next_state;
  mode_t  mode, next_mode;

  logic [7:0]       data_reg, setup_reg, hold_reg, rdata_reg;
  logic [15:0]      pw_reg;
  logic             err, done;
  logic             idle, cmd_wr, stat_wr, abort_req, start_req;
  logic             timer_load, timer_clr, timer_last;
  logic [CNT_W-1:0] timer_val;
  logic             sample_now, finish_now;

  assign idle      = (state == ST_IDLE);
  assign cmd_wr    = reg_we && (reg_addr == ADDR_CMD);
  assign stat_wr   = reg_we && (reg_addr == ADDR_STATUS);
  assign abort_req = cmd_wr && reg_wdata[CMD_ABORT_BIT];
  assign start_req = cmd_wr && !reg_wdata[CMD_ABORT_BIT] &&
                     (reg_wdata[CMD_PROG_BIT] || reg_wdata[CMD_READ_BIT]);

  zif_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (osc),
    .rst_n    (rst_n),
    .load     (timer_load),
    .clr      (timer_clr),
    .load_val (timer_val),
    .last     (timer_last)
  );

  // State and mode registers.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      mode  <= MODE_PROG;
    end else begin
      state <= next_state;
      mode  <= next_mode;
    end
  end

  // Next-state decode: abort beats everything, a read skips the pulse phase, and each phase entry reloads the timer.
  always_comb begin
    next_state = state;
    next_mode  = mode;
    timer_load = 1'b0;
    timer_val  = '0;
    sample_now = 1'b0;
    finish_now = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_req) begin
          next_state = ST_SETUP;
          next_mode  = reg_wdata[CMD_PROG_BIT] ? MODE_PROG : MODE_READ;
          timer_load = 1'b1;
          timer_val  = CNT_W'(setup_reg);
        end
      end
      ST_SETUP: begin
        if (abort_req) begin
          next_state = ST_IDLE;
        end else if (timer_last) begin
          timer_load = 1'b1;
          if (mode == MODE_PROG) begin
            next_state = ST_PULSE;
            timer_val  = CNT_W'(pw_reg);
          end else begin
            next_state = ST_HOLD;
            timer_val  = CNT_W'(hold_reg);
            sample_now = 1'b1;
          end
        end
      end
      ST_PULSE: begin
        if (abort_req) begin
          next_state = ST_IDLE;
        end else if (timer_last) begin
          next_state = ST_HOLD;
          timer_load = 1'b1;
          timer_val  = CNT_W'(hold_reg);
        end
      end
      ST_HOLD: begin
        if (abort_req) begin
          next_state = ST_IDLE;
        end else if (timer_last) begin
          next_state = ST_IDLE;
          finish_now = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    timer_clr = (next_state == ST_IDLE);
  end

  // Bus-writable configuration; frozen while a sequence runs so timing cannot shift mid-cycle.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= 8'h00;
      pw_reg    <= 16'(PULSE_RST);
      setup_reg <= 8'(SETUP_RST);
      hold_reg  <= 8'(HOLD_RST);
    end else if (reg_we && idle) begin
      case (reg_addr)
        ADDR_DATA:  data_reg     <= reg_wdata;
        ADDR_PW_LO: pw_reg[7:0]  <= reg_wdata;
        ADDR_PW_HI: pw_reg[15:8] <= reg_wdata;
        ADDR_SETUP: setup_reg    <= reg_wdata;
        ADDR_HOLD:  hold_reg     <= reg_wdata;
        default: ;
      endcase
    end
  end

  // Status flags and sampled read data; completion setting done outranks a coincident status clear.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      err       <= 1'b0;
      done      <= 1'b0;
      rdata_reg <= 8'h00;
    end else begin
      if (stat_wr) begin
        err <= 1'b0;
      end else if (!idle && start_req) begin
        err <= 1'b1;
      end
      if (finish_now) begin
        done <= 1'b1;
      end else if (stat_wr || (idle && start_req)) begin
        done <= 1'b0;
      end
      if (sample_now) begin
        rdata_reg <= zif_din;
      end
    end
  end

  // Pin outputs registered from the upcoming state so they switch on the same edge as the state.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      zif_doe  <= 1'b0;
      zif_dout <= 8'h00;
      prog_n   <= 1'b1;
      oe_n     <= 1'b1;
    end else begin
      busy    <= (next_state != ST_IDLE);
      zif_doe <= (next_state != ST_IDLE) && (next_mode == MODE_PROG);
      prog_n  <= (next_state != ST_PULSE);
      oe_n    <= !((next_state != ST_IDLE) && (next_mode == MODE_READ));
      if (idle && start_req && reg_wdata[CMD_PROG_BIT]) begin
        zif_dout <= data_reg;
      end
    end
  end

  // Register read-back mux.
  always_comb begin
    reg_rdata = 8'h00;
    case (reg_addr)
      ADDR_DATA:   reg_rdata = data_reg;
      ADDR_PW_LO:  reg_rdata = pw_reg[7:0];
      ADDR_PW_HI:  reg_rdata = pw_reg[15:8];
      ADDR_SETUP:  reg_rdata = setup_reg;
      ADDR_HOLD:   reg_rdata = hold_reg;
      ADDR_STATUS: begin
        reg_rdata[STAT_BUSY_BIT] = busy;
        reg_rdata[STAT_ERR_BIT]  = err;
        reg_rdata[STAT_DONE_BIT] = done;
      end
      ADDR_RDATA:  reg_rdata = rdata_reg;
      default:     reg_rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_zif_prog_sequencer.sv
// Self-checking bench for zif_prog_sequencer: directed scenarios plus randomized operations against a phase-window model.
module tb_zif_prog_sequencer;

  logic       osc = 1'b0;
  logic       rst_n = 1'b1;
  logic       reg_we = 1'b0;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] reg_wdata = 8'h00;
  logic [7:0] reg_rdata;
  logic       busy;
  logic [7:0] zif_dout;
  logic       zif_doe;
  logic [7:0] zif_din = 8'h00;
  logic       prog_n;
  logic       oe_n;

  int n_cmp  = 0;
  int n_fail = 0;

  zif_prog_sequencer dut (
    .osc       (osc),
    .rst_n     (rst_n),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .zif_dout  (zif_dout),
    .zif_doe   (zif_doe),
    .zif_din   (zif_din),
    .prog_n    (prog_n),
    .oe_n      (oe_n)
  );

  // 12 MHz oscillator (period ~83 ns).
  always #41 osc = ~osc;

  // Hard stop in case something stalls the main sequence.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge osc);
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    @(negedge osc);
    reg_we    = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [7:0] a, input logic [7:0] exp);
    reg_addr = a;
    #1;
    check_output(tag, reg_rdata, exp);
  endtask

  function automatic int at_least_one(input int n);
    return (n == 0) ? 1 : n;
  endfunction

  // Load registers, launch cmd, then compare every cycle against the expected phase windows.
  task automatic apply_stimulus(input logic [7:0] cmd, input logic [7:0] s, input logic [15:0] pw,
                                input logic [7:0] h, input logic [7:0] d, input logic [7:0] din);
    bit is_prog;
    int sl, pl, hl, len;
    is_prog = cmd[0];
    sl  = at_least_one(int'(s));
    pl  = is_prog ? at_least_one(int'(pw)) : 0;
    hl  = at_least_one(int'(h));
    len = sl + pl + hl;
    bus_write(8'h10, d);
    bus_write(8'h11, pw[7:0]);
    bus_write(8'h12, pw[15:8]);
    bus_write(8'h13, s);
    bus_write(8'h14, h);
    zif_din = din;
    bus_write(8'h15, cmd);
    for (int c = 1; c <= len + 1; c++) begin
      if (c > 1) @(negedge osc);
      check_output("busy", busy, 16'(c <= len));
      check_output("zif_doe", zif_doe, 16'(is_prog && c <= len));
      check_output("prog_n", prog_n, 16'(!(is_prog && c > sl && c <= sl + pl)));
      check_output("oe_n", oe_n, 16'(!(!is_prog && c <= len)));
      if (is_prog && c <= len) check_output("zif_dout", zif_dout, d);
    end
    check_reg("status_done", 8'h16, 8'h04);
    check_reg("setup_rb", 8'h13, s);
    check_reg("pw_lo_rb", 8'h11, pw[7:0]);
    if (!is_prog) check_reg("rdata", 8'h17, din);
  endtask

  initial begin
    int cyc;
    bit dropped;
    logic [7:0] cmd, s, h, d, din;
    logic [15:0] pw;

    // Reset defaults.
    #5 rst_n = 1'b0;
    repeat (2) @(negedge osc);
    rst_n = 1'b1;
    check_output("rst_prog_n", prog_n, 16'h1);
    check_output("rst_oe_n", oe_n, 16'h1);
    check_output("rst_doe", zif_doe, 16'h0);
    check_output("rst_busy", busy, 16'h0);
    check_output("rst_dout", zif_dout, 16'h00);
    check_reg("rst_status", 8'h16, 8'h00);
    check_reg("rst_setup", 8'h13, 8'h0C);
    check_reg("rst_hold", 8'h14, 8'h0C);
    check_reg("rst_pw_lo", 8'h11, 8'hB0);
    check_reg("rst_pw_hi", 8'h12, 8'h04);
    check_reg("rst_data", 8'h10, 8'h00);
    check_reg("rst_rdata", 8'h17, 8'h00);
    check_reg("unmapped", 8'h20, 8'h00);
    check_reg("cmd_rb", 8'h15, 8'h00);

    $display("[TB] directed program / read / zero timing");
    apply_stimulus(8'h01, 8'd2, 16'd3, 8'd1, 8'hA5, 8'h00);
    apply_stimulus(8'h02, 8'd4, 16'd0, 8'd2, 8'h00, 8'h3C);
    apply_stimulus(8'h01, 8'd0, 16'd0, 8'd0, 8'h5A, 8'h00);

    $display("[TB] randomized operations");
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(2, 0))
        0: cmd = 8'h01;
        1: cmd = 8'h02;
        default: cmd = 8'h03;
      endcase
      s   = 8'($urandom_range(5, 0));
      pw  = 16'($urandom_range(6, 0));
      h   = 8'($urandom_range(5, 0));
      d   = 8'($urandom);
      din = 8'($urandom);
      apply_stimulus(cmd, s, pw, h, d, din);
    end

    $display("[TB] busy collision");
    bus_write(8'h10, 8'h11);
    bus_write(8'h11, 8'd5);
    bus_write(8'h12, 8'd0);
    bus_write(8'h13, 8'd2);
    bus_write(8'h14, 8'd2);
    bus_write(8'h15, 8'h01);
    cyc = 1;
    repeat (2) begin @(negedge osc); cyc++; end
    bus_write(8'h13, 8'h50);
    cyc += 2;
    bus_write(8'h15, 8'h02);
    cyc += 2;
    check_output("coll_prog_n", prog_n, 16'h0);
    dropped = 1'b0;
    for (int k = 0; k < 40 && !dropped; k++) begin
      @(negedge osc);
      cyc++;
      if (!busy) dropped = 1'b1;
    end
    check_output("coll_dropped", 16'(dropped), 16'h1);
    check_output("coll_len", 16'(cyc), 16'd10);
    check_reg("coll_status", 8'h16, 8'h06);
    check_reg("coll_setup", 8'h13, 8'h02);
    bus_write(8'h16, 8'h00);
    check_reg("coll_clear", 8'h16, 8'h00);

    $display("[TB] abort mid-pulse");
    bus_write(8'h13, 8'd1);
    bus_write(8'h11, 8'd10);
    bus_write(8'h14, 8'd1);
    bus_write(8'h15, 8'h01);
    @(negedge osc);
    check_output("abort_pre_prog_n", prog_n, 16'h0);
    bus_write(8'h15, 8'h81);
    check_output("abort_prog_n", prog_n, 16'h1);
    check_output("abort_busy", busy, 16'h0);
    check_output("abort_doe", zif_doe, 16'h0);
    check_output("abort_oe_n", oe_n, 16'h1);
    check_reg("abort_status", 8'h16, 8'h00);
    bus_write(8'h15, 8'h80);
    check_output("idle_abort_busy", busy, 16'h0);
    check_reg("idle_abort_status", 8'h16, 8'h00);

    $display("[TB] reset mid-pulse");
    bus_write(8'h15, 8'h01);
    @(negedge osc);
    check_output("rstmid_pre_prog_n", prog_n, 16'h0);
    #5 rst_n = 1'b0;
    #1;
    check_output("rstmid_prog_n", prog_n, 16'h1);
    check_output("rstmid_busy", busy, 16'h0);
    check_output("rstmid_doe", zif_doe, 16'h0);
    repeat (2) @(negedge osc);
    rst_n = 1'b1;
    check_reg("rstmid_setup", 8'h13, 8'h0C);
    check_reg("rstmid_status", 8'h16, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
